hdc_session_sequencer: RTL
==========================

HDC_SESSION_SEQUENCER -- requirements
Module: hdc_session_sequencer

Interface
REQ-001 Parameter CLASS_W, 5, width of class label.
REQ-002 Parameter MAP_CYCLES, 10, cycles per mapping slot (legal >=2).
REQ-003 Parameter BIN_CYCLES, 259, cycles allowed for class-HV binarization (legal >=1).
REQ-004 clk  in  1  single clock, all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  admission enable: gates session start and sample acceptance only.
REQ-007 go  in  1  start-session strobe.
REQ-008 sample_valid  in  1  sample store has a sample on the HDC input bus.
REQ-009 sample_label  in  CLASS_W  label of offered sample.
REQ-010 sample_last  in  1  offered sample is last of current phase.
REQ-011 sample_ready  out  1  sample accepted when sample_valid & sample_ready.
REQ-012 start_mapping  out  1  one-cycle mapping start pulse to HDC core.
REQ-013 class_select_bits  out  CLASS_W  label delayed two samples, aligned to HDC pipeline.
REQ-014 training_dataset_finished  out  1  one-cycle pulse, end of training phase.
REQ-015 testing_dataset_finished  out  1  one-cycle pulse, end of testing phase.
REQ-016 phase_test  out  1  0 = training phase, 1 = testing phase.
REQ-017 busy  out  1  high in any state except IDLE and DONE.
REQ-018 done  out  1  high in DONE.
REQ-019 train_count, test_count  out  11 each  accepted-sample counters.

Function
REQ-020 States SHALL be IDLE, WAIT, MAP, DRAIN, FINISH, BIN, DONE; all outputs registered.
REQ-021 IDLE or DONE: go & en -> WAIT, phase_test=0, label pipeline cleared to 0; go ignored elsewhere.
REQ-022 sample_ready SHALL equal (state==WAIT) & en.
REQ-023 Acceptance at cycle t -> start_mapping=1 at t+1 only; MAP occupies t+1..t+MAP_CYCLES; WAIT again at t+MAP_CYCLES+1 (min sample period MAP_CYCLES+1).
REQ-024 Label pipeline: 2-stage shift on each acceptance; class_select_bits updates in start_mapping cycle to label of sample accepted two acceptances earlier (0 before two accepted).
REQ-025 Acceptance with sample_last -> after its MAP slot, DRAIN runs min(2, samples accepted in phase) slots of MAP_CYCLES cycles, shifting pipeline (0 in) at each slot's first cycle, no start_mapping.
REQ-026 After DRAIN, FINISH one cycle: training_dataset_finished (phase 0) or testing_dataset_finished (phase 1) =1.
REQ-027 Phase 0: FINISH -> BIN for BIN_CYCLES cycles -> WAIT with phase_test=1, pipeline cleared.
REQ-028 Phase 1: FINISH -> DONE; done held until next go.
REQ-029 en=0 in MAP/DRAIN/BIN SHALL NOT stall; slots complete normally.
REQ-030 sample_valid outside WAIT SHALL be ignored; sample_label/sample_last sampled only at acceptance.

Reset
REQ-031 rst=1 at any time -> IDLE asynchronously; all outputs, counters, pipeline 0.
REQ-032 Reset mid-session discards session; no finished pulse emitted.

Configuration
REQ-033 Macro HDC_SEQ_STATS_EN defined: train_count/test_count increment per acceptance in phase, saturate at 2047, clear on go.
REQ-034 Macro undefined: train_count and test_count tied to 0; all other behaviour identical.

Verification
REQ-035 Train 3 samples labels 4,7,9 (last on 3rd), then 2 test samples, MAP_CYCLES=10 -> start_mapping every 11 cycles; class_select_bits 0,0,4 at starts, 7,9 in drain slots.
REQ-036 1-sample training phase, label 5 -> one drain slot showing 5, training_dataset_finished 11 cycles after the slot ends... (MAP end + 10 drain +1), then BIN for 259 cycles, phase_test rises.
REQ-037 en=0 while sample_valid=1 in WAIT -> sample_ready=0, no start_mapping; en=1 -> accepted next cycle.
REQ-038 rst asserted during BIN cycle 100 -> all outputs 0 immediately, IDLE; go restarts at phase 0.
REQ-039 go during MAP ignored; go in DONE restarts, counters cleared (HDC_SEQ_STATS_EN) and count 2 train/2 test -> train_count=2, test_count=2.
REQ-040 sample_valid held continuously with no back-pressure gaps -> exactly one acceptance per 11-cycle period, no duplicate start_mapping.

Source files
------------

// File: rtl/hdc_session_sequencer.sv
// HDC session sequencer: paces samples into the HDC core, drains its
// label pipeline, and steps the train -> binarize -> test session.
// Optional per-phase sample counters: define HDC_SEQ_STATS_EN.
module hdc_session_sequencer #(
    parameter int CLASS_W    = 5,
    parameter int MAP_CYCLES = 10,
    parameter int BIN_CYCLES = 259
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               go,
    input  logic               sample_valid,
    input  logic [CLASS_W-1:0] sample_label,
    input  logic               sample_last,
    output logic               sample_ready,
    output logic               start_mapping,
    output logic [CLASS_W-1:0] class_select_bits,
    output logic               training_dataset_finished,
    output logic               testing_dataset_finished,
    output logic               phase_test,
    output logic               busy,
    output logic               done,
    output logic [10:0]        train_count,
    output logic [10:0]        test_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_MAP    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_BIN    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [15:0] MAP_LAST = 16'(MAP_CYCLES - 1);
    localparam logic [15:0] BIN_LAST = 16'(BIN_CYCLES - 1);

    logic [2:0]         state;
    logic [15:0]        cnt;
    logic               last_q;
    logic [1:0]         acc_cnt;
    logic               drain_left;
    logic [CLASS_W-1:0] p0;
    logic [CLASS_W-1:0] p1;
    logic               go_ok;
    logic               accept;

    assign go_ok  = go & en & ((state == S_IDLE) | (state == S_DONE));
    assign accept = (state == S_WAIT) & en & sample_valid;

    // Status decodes straight off the state register.
    assign sample_ready = (state == S_WAIT) & en;
    assign busy         = (state != S_IDLE) & (state != S_DONE);
    assign done         = (state == S_DONE);

    // Session FSM, slot timer and the two-deep label pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                     <= S_IDLE;
            cnt                       <= '0;
            last_q                    <= 1'b0;
            acc_cnt                   <= '0;
            drain_left                <= 1'b0;
            p0                        <= '0;
            p1                        <= '0;
            class_select_bits         <= '0;
            start_mapping             <= 1'b0;
            training_dataset_finished <= 1'b0;
            testing_dataset_finished  <= 1'b0;
            phase_test                <= 1'b0;
        end else begin
            start_mapping             <= 1'b0;
            training_dataset_finished <= 1'b0;
            testing_dataset_finished  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (go_ok) begin
                        state             <= S_WAIT;
                        phase_test        <= 1'b0;
                        p0                <= '0;
                        p1                <= '0;
                        class_select_bits <= '0;
                        acc_cnt           <= '0;
                        last_q            <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (accept) begin
                        state             <= S_MAP;
                        cnt               <= '0;
                        start_mapping     <= 1'b1;
                        p0                <= sample_label;
                        p1                <= p0;
                        class_select_bits <= p1;
                        last_q            <= sample_last;
                        if (acc_cnt != 2'd2)
                            acc_cnt <= acc_cnt + 2'd1;
                    end
                end
                S_MAP: begin
                    if (cnt == MAP_LAST) begin
                        cnt <= '0;
                        if (last_q) begin
                            state <= S_DRAIN;
                            // A lone sample has nothing in the older stage,
                            // so its single drain slot presents it directly.
                            if (acc_cnt == 2'd1) begin
                                class_select_bits <= p0;
                                p1                <= '0;
                                drain_left        <= 1'b0;
                            end else begin
                                class_select_bits <= p1;
                                p1                <= p0;
                                drain_left        <= 1'b1;
                            end
                            p0 <= '0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == MAP_LAST) begin
                        cnt <= '0;
                        if (drain_left) begin
                            drain_left        <= 1'b0;
                            class_select_bits <= p1;
                            p1                <= p0;
                            p0                <= '0;
                        end else begin
                            state <= S_FINISH;
                            if (phase_test)
                                testing_dataset_finished <= 1'b1;
                            else
                                training_dataset_finished <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_FINISH: begin
                    cnt   <= '0;
                    state <= phase_test ? S_DONE : S_BIN;
                end
                S_BIN: begin
                    if (cnt == BIN_LAST) begin
                        cnt               <= '0;
                        state             <= S_WAIT;
                        phase_test        <= 1'b1;
                        p0                <= '0;
                        p1                <= '0;
                        class_select_bits <= '0;
                        acc_cnt           <= '0;
                        last_q            <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HDC_SEQ_STATS_EN
    // Saturating per-phase acceptance counters, cleared on session start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            train_count <= '0;
            test_count  <= '0;
        end else if (go_ok) begin
            train_count <= '0;
            test_count  <= '0;
        end else if (accept) begin
            if (phase_test) begin
                if (test_count != 11'h7FF)
                    test_count <= test_count + 11'd1;
            end else begin
                if (train_count != 11'h7FF)
                    train_count <= train_count + 11'd1;
            end
        end
    end
`else
    assign train_count = '0;
    assign test_count  = '0;
`endif

endmodule
